// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants and state encoding for the RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
   localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

   localparam logic [2:0] F3_MUL  = 3'b000;
   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiplier and restoring divider sharing one
// accumulator, one shift register and a down-counting iteration timer.
module muldiv_iter_core #(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] shreg,
   output logic             tc
);

   localparam int CW = $clog2(ITER + 1);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] mul_sum;

   // a_q is the multiplicand (MUL) or the dividend turning into the quotient (DIV);
   // b_q is the multiplier (MUL) or the divisor (DIV).
   always_comb begin
      shifted = {acc_q, a_q[WIDTH-1]};
      fits    = shifted >= {1'b0, b_q};
      div_rem = fits ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
      mul_sum = acc_q + (b_q[0] ? a_q : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         acc_q <= '0;
         a_q   <= op_a;
         b_q   <= op_b;
         cnt_q <= CW'(ITER - 1);
      end else if (step) begin
         if (div_mode) begin
            acc_q <= div_rem;
            a_q   <= {a_q[WIDTH-2:0], fits};
         end else begin
            acc_q <= mul_sum;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
         end
         if (!tc) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign tc    = (cnt_q == '0);
   assign acc   = acc_q;
   assign shreg = a_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage sequencer for RV32M MUL/DIV/DIVU/REM/REMU: pipeline stall,
// sign handling, RISC-V special cases and a one-cycle result handshake.
//
// state | meaning
// IDLE  | waiting for an M-type instruction; accepts when valid and not flushed
// MUL   | ITER shift-add iterations
// DIV   | ITER restoring-division iterations on absolute values
// FIX   | apply result sign, load result register
// DONE  | result_o valid, done_o pulsed, pipeline released
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [9:0]       funct_i,
   input  logic [WIDTH-1:0] rs1_i,
   input  logic [WIDTH-1:0] rs2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   muldiv_state_e    state_q, state_d;
   logic [2:0]       f3_q;
   logic             q_neg_q;
   logic             r_neg_q;
   logic [WIDTH-1:0] result_q;

   logic [6:0]       f7;
   logic [2:0]       f3;
   logic             is_div_op, is_signed, supported;
   logic             div_zero, overflow, short_path, accept;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] op_a, op_b, short_res, fix_res;
   logic             core_load, core_step, core_tc;
   logic [WIDTH-1:0] core_acc, core_shreg;

   assign f7 = funct_i[9:3];
   assign f3 = funct_i[2:0];

   always_comb begin
      is_div_op  = (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
      is_signed  = (f3 == F3_DIV) || (f3 == F3_REM);
      supported  = (f7 == FUNCT7_MULDIV) && ((f3 == F3_MUL) || is_div_op);
      div_zero   = is_div_op && (rs2_i == '0);
      overflow   = is_signed && (rs1_i == MIN_NEG) && (rs2_i == '1);
      short_path = !supported || div_zero || overflow;
      a_neg      = is_signed && rs1_i[WIDTH-1];
      b_neg      = is_signed && rs2_i[WIDTH-1];
      op_a       = a_neg ? -rs1_i : rs1_i;
      op_b       = b_neg ? -rs2_i : rs2_i;
   end

   // Results that never touch the iterative core.
   always_comb begin
      short_res = '0;
      if (supported && div_zero) begin
         short_res = ((f3 == F3_DIV) || (f3 == F3_DIVU)) ? '1 : rs1_i;
      end else if (supported && overflow) begin
         short_res = (f3 == F3_DIV) ? MIN_NEG : '0;
      end
   end

   always_comb begin
      fix_res = '0;
      unique case (f3_q)
         F3_MUL:  fix_res = core_acc;
         F3_DIV:  fix_res = q_neg_q ? -core_shreg : core_shreg;
         F3_DIVU: fix_res = core_shreg;
         F3_REM:  fix_res = r_neg_q ? -core_acc : core_acc;
         F3_REMU: fix_res = core_acc;
         default: fix_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      stall_o   = 1'b0;
      accept    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid_i && !flush_i) begin
               accept    = 1'b1;
               stall_o   = 1'b1;
               core_load = !short_path;
               if (short_path) begin
                  state_d = DONE;
               end else if (f3 == F3_MUL) begin
                  state_d = MUL;
               end else begin
                  state_d = DIV;
               end
            end
         end
         MUL, DIV: begin
            stall_o   = 1'b1;
            core_step = 1'b1;
            if (flush_i) begin
               state_d = IDLE;
            end else if (core_tc) begin
               state_d = FIX;
            end
         end
         FIX: begin
            stall_o = 1'b1;
            state_d = flush_i ? IDLE : DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         f3_q     <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            f3_q    <= f3;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            if (short_path) begin
               result_q <= short_res;
            end
         end
         if ((state_q == FIX) && !flush_i) begin
            result_q <= fix_res;
         end
      end
   end

   muldiv_iter_core #(
      .WIDTH (WIDTH),
      .ITER  (ITER)
   ) u_core (
      .clk      (clk_i),
      .rst      (rst_i),
      .load     (core_load),
      .step     (core_step),
      .div_mode (state_q == DIV),
      .op_a     (op_a),
      .op_b     (op_b),
      .acc      (core_acc),
      .shreg    (core_shreg),
      .tc       (core_tc)
   );

   assign busy_o   = (state_q != IDLE);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall profile, results,
// special cases, flush and mid-operation reset.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [9:0]  funct;
   logic [31:0] rs1, rs2;
   logic        flush;
   logic        stall, busy, done;
   logic [31:0] result;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(32), .ITER(32)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .valid_i  (valid),
      .funct_i  (funct),
      .rs1_i    (rs1),
      .rs2_i    (rs2),
      .flush_i  (flush),
      .stall_o  (stall),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called just after a rising edge; that cycle is cycle 0 of the operation.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] exp_res);
      int cyc = 0;
      int stall_cnt = 0;
      bit seen = 1'b0;
      valid = 1'b1;
      funct = {FUNCT7_MULDIV, f3};
      rs1   = a;
      rs2   = b;
      while (!seen && cyc <= 60) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
         end else begin
            if (stall) stall_cnt++;
            cyc++;
            @(posedge clk); #1;
         end
      end
      chk({tag, " done_cycle"}, cyc, lat);
      chk({tag, " stall_cycles"}, stall_cnt, lat);
      chk({tag, " result"}, result, exp_res);
      chk({tag, " stall_at_done"}, {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      rst   = 1'b1;
      valid = 1'b0;
      flush = 1'b0;
      funct = '0;
      rs1   = '0;
      rs2   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset busy",   {31'b0, busy},  32'd0);
      chk("reset done",   {31'b0, done},  32'd0);
      chk("reset stall",  {31'b0, stall}, 32'd0);
      chk("reset result", result,         32'd0);
      @(posedge clk); #1;

      run_op("mul 7*-3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
      @(negedge clk);
      chk("mul done pulse width", {31'b0, done}, 32'd0);
      chk("mul idle after done",  {31'b0, busy}, 32'd0);
      chk("mul result held",      result,        32'hFFFF_FFEB);
      @(posedge clk); #1;

      run_op("div -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
      run_op("rem -7%2", F3_REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);

      run_op("divu 100/0", F3_DIVU, 32'd100, 32'd0, 1, 32'hFFFF_FFFF);
      run_op("remu 100%0", F3_REMU, 32'd100, 32'd0, 1, 32'd100);

      // Flush a MUL at cycle 10: no result, prior result kept.
      valid = 1'b1;
      funct = {FUNCT7_MULDIV, F3_MUL};
      rs1   = 32'd5;
      rs2   = 32'd6;
      repeat (10) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      chk("flush busy",   {31'b0, busy},  32'd0);
      chk("flush stall",  {31'b0, stall}, 32'd0);
      chk("flush done",   {31'b0, done},  32'd0);
      chk("flush result", result,         32'd100);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("flush no done pulse", pulses, 32'd0);
      chk("flush result kept",   result, 32'd100);
      @(posedge clk); #1;

      run_op("rem ovf",     F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
      run_op("unsupported", 3'b001, 32'd9,         32'd9,         1, 32'd0);
      run_op("div ovf",     F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);

      // Reset at cycle 20 of a DIV.
      valid = 1'b1;
      funct = {FUNCT7_MULDIV, F3_DIV};
      rs1   = 32'd1000;
      rs2   = 32'd7;
      repeat (20) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("div busy before reset", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      chk("midop reset busy",   {31'b0, busy},  32'd0);
      chk("midop reset done",   {31'b0, done},  32'd0);
      chk("midop reset stall",  {31'b0, stall}, 32'd0);
      chk("midop reset result", result,         32'd0);
      @(posedge clk); #1;

      run_op("divu 10/3", F3_DIVU, 32'd10, 32'd3, 34, 32'd3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M multiply/divide instructions in the EX stage of the pipelined CPU.
- Instructions are qualified by ALUOp = 2'b10 with funct7 = 7'b0000001; the EX-stage decode drives valid_i.
- Accepts one operation, stalls the pipeline while an iterative shift-add multiplier or restoring divider runs, then presents the result for one cycle.
- The single-cycle ALU remains untouched; EX muxes result_o in when done_o = 1.

Parameters:
- WIDTH, 32, operand/result width.
- ITER, WIDTH, iteration count for the MUL and DIV states.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  EX holds an M-type instruction.
- funct_i  in  10  {funct7, funct3} of the EX instruction.
- rs1_i  in  WIDTH  operand A (dividend / multiplicand).
- rs2_i  in  WIDTH  operand B (divisor / multiplier).
- flush_i  in  1  EX instruction squashed (branch/exception).
- stall_o  out  1  hold IF/ID/EX; combinational.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  result valid this cycle; one-cycle pulse.
- result_o  out  WIDTH  registered result; held between operations.

Behaviour:
- Reset (rst_i sampled high at clk edge): state = IDLE; all datapath registers = 0; result_o = 0; done_o = 0; busy_o = 0. stall_o = 0 unless valid_i is high in IDLE on the following cycles. Reset overrides flush_i and any in-progress operation.
- Supported funct3 codes:
  - 000 MUL: low WIDTH bits of the product.
  - 100 DIV: signed quotient.
  - 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder.
  - 111 REMU: unsigned remainder.
  - 001/010/011: unsupported; take the short path with result 0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE, with valid_i = 1 and flush_i = 0 (accept, cycle 0):
  - stall_o = 1 combinationally.
  - Latch the operation; latch operands as absolute values for signed DIV/REM, recording the quotient sign and remainder sign.
  - Next state is MUL or DIV.
  - Short path goes straight to DONE: divisor = 0, signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM), or unsupported funct3.
- MUL / DIV: exactly ITER cycles. An iteration counter counts 0..ITER-1, then transitions to FIX. MUL does shift-add, one bit per cycle. DIV does restoring division, one quotient bit per cycle. stall_o = 1.
- FIX: one cycle. Applies two's-complement negation of the quotient/remainder per the latched signs (MUL passes through), then goes to DONE. stall_o = 1.
- DONE: one cycle. result_o loads on entry; done_o = 1; stall_o = 0, so the pipeline advances. Next state = IDLE. valid_i is ignored in DONE because it still reflects the completing instruction.
- Latency:
  - Normal path: accept at cycle 0, done_o at cycle ITER+2 (34 for WIDTH = 32); stall_o high for cycles 0..ITER+1.
  - Short path: done_o at cycle 1; stall_o high in cycle 0 only.
- Special results (RISC-V semantics):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow: quotient = 0x80000000; remainder = 0.
- flush_i:
  - In IDLE: blocks acceptance.
  - In MUL/DIV/FIX: next state = IDLE; no done_o; result_o unchanged; stall_o = 0 from the next cycle.
  - In DONE: done_o still asserted that cycle (the pipeline discards it).
- Back-to-back: a new valid_i is accepted only in the cycle after DONE (IDLE), never in DONE itself.
- All arithmetic is modulo 2^WIDTH. The MUL product register is WIDTH bits; upper product bits are discarded.

Decomposition:
- Shared package holds:
  - FUNCT7_MULDIV = 7'b0000001.
  - funct3 codes F3_MUL/F3_DIV/F3_DIVU/F3_REM/F3_REMU.
  - State encoding (IDLE = 0, MUL, DIV, FIX, DONE).
  - ALUOP_RTYPE = 2'b10.
- One natural sub-module: muldiv_iter_core, the shared shift/add/subtract datapath with the iteration counter. The sequencer owns the FSM, sign handling, special cases and handshake.

Test Plan:
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD (-3): stall_o high cycles 0..33; done_o at cycle 34; result_o = 0xFFFFFFEB (-21).
- DIV then REM, rs1 = 0xFFFFFFF9 (-7), rs2 = 2: results 0xFFFFFFFD (-3) and 0xFFFFFFFF (-1). Each takes 34 cycles; the second is accepted the cycle after the first DONE.
- DIVU rs1 = 100, rs2 = 0: done_o at cycle 1, result_o = 0xFFFFFFFF. REMU with the same operands: result_o = 100.
- DIV rs1 = 0x80000000, rs2 = 0xFFFFFFFF: done_o at cycle 1, result_o = 0x80000000. REM with the same operands: result_o = 0.
- MUL accepted, flush_i pulsed at cycle 10: state IDLE at cycle 11; stall_o = 0; done_o never pulses; result_o keeps its prior value.
- rst_i asserted at cycle 20 of a DIV: next cycle state IDLE, result_o = 0, done_o = 0, busy_o = 0. A new DIVU 10/3 then yields result_o = 3 at cycle 34 after accept.
